// File: rtl/vc_occupancy_tracker_if.sv
// Flit-send and credit-return signals between the VC allocator/link side and
// the downstream VC occupancy bank.
interface vc_occupancy_tracker_if #(
    parameter int VC_NUM = 4
);
    logic              flit_valid;
    logic [VC_NUM-1:0] flit_vc;
    logic              flit_is_head;
    logic              flit_is_tail;
    logic              credit_valid;
    logic [VC_NUM-1:0] credit_vc;

    modport master (
        output flit_valid, flit_vc, flit_is_head, flit_is_tail,
        output credit_valid, credit_vc
    );

    modport slave (
        input flit_valid, flit_vc, flit_is_head, flit_is_tail,
        input credit_valid, credit_vc
    );
endinterface

// File: rtl/vc_occupancy_tracker.sv
// Per-output-port downstream VC occupancy counters plus FREE/BUSY/DRAIN ownership FSMs.
// Optional macro OCC_LOOKAHEAD_EN drives occ_array/vc_full from the next-state counts.
module vc_occupancy_tracker #(
    parameter int VC_NUM          = 4,
    parameter int DATA_WIDTH      = 5,
    parameter int BUFFER_DEPTH    = 8,
    parameter int OUT_ARRAY_WIDTH = VC_NUM * DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    vc_occupancy_tracker_if.slave      link,
    output logic [OUT_ARRAY_WIDTH-1:0] occ_array,
    output logic [VC_NUM-1:0]          vc_full,
    output logic [VC_NUM-1:0]          vc_free,
    output logic [2:0]                 err
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } vc_state_t;

    localparam logic [DATA_WIDTH-1:0] DEPTH_C = DATA_WIDTH'(BUFFER_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ZERO_C  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_C   = DATA_WIDTH'(1);
    localparam logic [VC_NUM-1:0]     ONE_V   = VC_NUM'(1);

    function automatic logic is_onehot(input logic [VC_NUM-1:0] v);
        return (v != {VC_NUM{1'b0}}) && ((v & (v - ONE_V)) == {VC_NUM{1'b0}});
    endfunction

    logic [DATA_WIDTH-1:0] r_count      [VC_NUM];
    logic [DATA_WIDTH-1:0] w_count_next [VC_NUM];
    vc_state_t             r_state      [VC_NUM];
    vc_state_t             w_state_next [VC_NUM];
    logic [VC_NUM-1:0]     r_full;
    logic [VC_NUM-1:0]     r_free;
    logic [2:0]            r_err;
    logic [2:0]            w_err_next;
    logic [VC_NUM-1:0]     w_inc, w_dec, w_ovf, w_unf, w_proto_vc;
    logic                  w_flit_ok, w_flit_bad, w_cred_ok, w_cred_bad;

    // A malformed select discards the whole event and only raises the protocol flag.
    assign w_flit_ok  = link.flit_valid & is_onehot(link.flit_vc);
    assign w_flit_bad = link.flit_valid & ~is_onehot(link.flit_vc);
    assign w_cred_ok  = link.credit_valid & is_onehot(link.credit_vc);
    assign w_cred_bad = link.credit_valid & ~is_onehot(link.credit_vc);
    assign w_inc      = {VC_NUM{w_flit_ok}} & link.flit_vc;
    assign w_dec      = {VC_NUM{w_cred_ok}} & link.credit_vc;

    // Next-state occupancy counts with overflow/underflow detection.
    always_comb begin
        w_ovf = {VC_NUM{1'b0}};
        w_unf = {VC_NUM{1'b0}};
        for (int i = 0; i < VC_NUM; i++) begin
            w_count_next[i] = r_count[i];
            if (!reset) begin
                w_count_next[i] = ZERO_C;
            end else if (w_inc[i] && !w_dec[i]) begin
                if (r_count[i] == DEPTH_C) begin
                    w_ovf[i] = 1'b1;
                end else begin
                    w_count_next[i] = r_count[i] + ONE_C;
                end
            end else if (w_dec[i] && !w_inc[i]) begin
                if (r_count[i] == ZERO_C) begin
                    w_unf[i] = 1'b1;
                end else begin
                    w_count_next[i] = r_count[i] - ONE_C;
                end
            end else begin
                w_count_next[i] = r_count[i];
            end
        end
    end

    // Next-state VC ownership FSMs and packet-protocol violations.
    always_comb begin
        w_proto_vc = {VC_NUM{1'b0}};
        for (int i = 0; i < VC_NUM; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                ST_FREE: begin
                    if (w_inc[i] && link.flit_is_head) begin
                        w_state_next[i] = link.flit_is_tail ? ST_DRAIN : ST_BUSY;
                    end else if (w_inc[i]) begin
                        w_proto_vc[i] = 1'b1;
                    end else begin
                        w_state_next[i] = ST_FREE;
                    end
                end
                ST_BUSY: begin
                    if (w_inc[i] && link.flit_is_head) begin
                        w_proto_vc[i] = 1'b1;
                    end else if (w_inc[i] && link.flit_is_tail) begin
                        w_state_next[i] = ST_DRAIN;
                    end else begin
                        w_state_next[i] = ST_BUSY;
                    end
                end
                ST_DRAIN: begin
                    if (w_inc[i] && (link.flit_is_head || link.flit_is_tail)) begin
                        w_proto_vc[i] = 1'b1;
                    end else begin
                        w_proto_vc[i] = 1'b0;
                    end
                    // Release happens on the edge that retires the last credit.
                    if (w_count_next[i] == ZERO_C) begin
                        w_state_next[i] = ST_FREE;
                    end else begin
                        w_state_next[i] = ST_DRAIN;
                    end
                end
                default: begin
                    w_state_next[i] = ST_FREE;
                end
            endcase
        end
    end

    // Sticky error accumulation.
    always_comb begin
        w_err_next = r_err | {(|w_proto_vc) | w_flit_bad | w_cred_bad, |w_unf, |w_ovf};
    end

    // State, count and registered-output updates with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < VC_NUM; i++) begin
                r_count[i] <= ZERO_C;
                r_state[i] <= ST_FREE;
            end
            r_full <= {VC_NUM{1'b0}};
            r_free <= {VC_NUM{1'b1}};
            r_err  <= 3'b000;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                r_count[i] <= w_count_next[i];
                r_state[i] <= w_state_next[i];
                r_full[i]  <= (w_count_next[i] == DEPTH_C);
                r_free[i]  <= (w_state_next[i] == ST_FREE);
            end
            r_err <= w_err_next;
        end
    end

    // Output packing; lookahead build exposes next-state counts to the selector.
    always_comb begin
        occ_array = {OUT_ARRAY_WIDTH{1'b0}};
        vc_full   = {VC_NUM{1'b0}};
        for (int i = 0; i < VC_NUM; i++) begin
`ifdef OCC_LOOKAHEAD_EN
            occ_array[i*DATA_WIDTH +: DATA_WIDTH] = w_count_next[i];
            vc_full[i]                            = (w_count_next[i] == DEPTH_C);
`else
            occ_array[i*DATA_WIDTH +: DATA_WIDTH] = r_count[i];
            vc_full[i]                            = r_full[i];
`endif
        end
        vc_free = r_free;
        err     = r_err;
    end

endmodule

// File: doc/vc_occupancy_tracker.md
Name: vc_occupancy_tracker

Overview:
Per-output-port bank of downstream VC occupancy counters and VC ownership state machines. It produces the packed per-VC occupancy array that the minimum-number selector consumes to pick the least-loaded VC.
- Counts flits sent into each downstream VC (+1) and credits returned from the downstream router (−1).
- Tracks each VC through its packet lifetime: free, busy, draining.
- Sits between the output-port VC allocator and the link/credit interface.

Parameters:
VC_NUM, 4, number of downstream VCs.
DATA_WIDTH, 5, width of one occupancy count.
BUFFER_DEPTH, 8, downstream VC buffer depth; must be ≤ 2^DATA_WIDTH−1.
OUT_ARRAY_WIDTH, VC_NUM*DATA_WIDTH, width of the packed occupancy output.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous active-low reset; sampled on rising clk edge.
flit_valid  input  1  a flit is sent on the link this cycle.
flit_vc  input  VC_NUM  one-hot target VC of the sent flit.
flit_is_head  input  1  sent flit is a head flit.
flit_is_tail  input  1  sent flit is a tail flit; head and tail may both be set for a single-flit packet.
credit_valid  input  1  one credit is returned this cycle.
credit_vc  input  VC_NUM  one-hot VC of the returned credit.
occ_array  output  OUT_ARRAY_WIDTH  packed counts; VC i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
vc_full  output  VC_NUM  count == BUFFER_DEPTH.
vc_free  output  VC_NUM  VC is in state FREE.
err  output  3  sticky error flags: {protocol, underflow, overflow}.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all counts 0, all VCs FREE.
  - occ_array=0, vc_full=0, vc_free=all ones, err=0.
  - Reset applied mid-packet discards all state the same way.
- Latency: all outputs are registered. An event at edge N is visible after edge N.
- Count update per VC i:
  - inc = flit_valid & flit_vc[i]; dec = credit_valid & credit_vc[i].
  - inc & dec together: count unchanged.
  - inc alone at count==BUFFER_DEPTH: count held, err[0] set.
  - dec alone at count==0: count held, err[1] set.
  - Otherwise count ±1.
- Select validation:
  - flit_vc or credit_vc not one-hot while its valid is high: that event is ignored entirely and err[2] is set.
  - A zero-hot select with valid low is a no-op.
- Per-VC state machine (FREE, BUSY, DRAIN):
  - FREE + head & !tail → BUSY.
  - FREE + head & tail → DRAIN.
  - BUSY + tail → DRAIN.
  - DRAIN when the next count is 0 → FREE. This may coincide with the last credit; vc_free rises the cycle after that credit.
  - Head on a non-FREE VC: err[2] set; count still updates; state unchanged.
  - Non-head flit to a FREE VC: err[2] set; count still updates.
  - Tail in DRAIN: err[2] set; state unchanged.
- err bits are sticky until reset.
- The bank never gates flit_valid itself. Back-pressure is the sender's job, driven by vc_full.

Optional Feature:
Macro OCC_LOOKAHEAD_EN.
- Defined: occ_array and vc_full are driven combinationally from the next-state counts, giving zero-cycle visibility to the minimum selector. vc_free and err remain registered.
- Undefined: all outputs are registered, as described in Behaviour.

Test Plan:
1. Reset, then idle 3 cycles → occ_array=0, vc_free=4'b1111, err=0.
2. Head+body+tail (3 flits) to VC2 on consecutive cycles.
   → After tail: occ of VC2=3, vc_free=4'b1011, VC2 in DRAIN.
   → 3 credits to VC2: count reaches 0 and vc_free=4'b1111 one cycle after the 3rd credit.
3. Fill VC0 to 8 flits → vc_full[0]=1. A 9th flit → count stays 8, err=3'b001.
4. Same cycle: flit to VC1 and credit to VC1 with count 4 → count stays 4. Flit to VC3 and credit to VC1 at VC1 count 4 → VC3 +1, VC1=3.
5. Credit to VC3 at count 0 → err=3'b010. Then flit_vc=4'b0110 with valid → no count change, err=3'b110.
6. With OCC_LOOKAHEAD_EN defined: flit to VC1 at edge N → occ_array shows VC1=1 combinationally before edge N, and equals the registered value after edge N.
